// File: rtl/rr_mux4_arbiter_pkg.sv
// ============================================================
// rr_mux4_arbiter_pkg : shared types/constants for the 4-way RR arbiter
// Rev 1.0
// ============================================================
`default_nettype none

package rr_mux4_arbiter_pkg;

  localparam int c_NUM_REQ = 4;
  localparam int c_SEL_W   = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // First set bit of i_mask found scanning from i_ptr upward, wrapping mod 4.
  function automatic logic [c_SEL_W-1:0] rr_pick(
    input logic [c_NUM_REQ-1:0] i_mask,
    input logic [c_SEL_W-1:0]   i_ptr
  );
    logic [c_SEL_W-1:0] v_idx;
    logic [c_SEL_W-1:0] v_pick;
    v_pick = i_ptr;
    for (int i = c_NUM_REQ - 1; i >= 0; i--) begin
      v_idx = i_ptr + c_SEL_W'(i);
      if (i_mask[v_idx]) v_pick = v_idx;
    end
    return v_pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux4_arbiter_mux4_w.sv
// ============================================================
// mux4_w : W-bit 4-to-1 combinational multiplexer
// Rev 1.0
// ============================================================
`default_nettype none

module mux4_w
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0]       i_d0,
  input  logic [W-1:0]       i_d1,
  input  logic [W-1:0]       i_d2,
  input  logic [W-1:0]       i_d3,
  input  logic [c_SEL_W-1:0] i_sel,
  output logic [W-1:0]       o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux4_arbiter.sv
// ============================================================
// rr_mux4_arbiter : round-robin 4-requester arbiter with bounded hold
//                   and shared data channel mux
// Rev 1.0
// ============================================================
`default_nettype none

module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [c_NUM_REQ-1:0] req,
  input  logic [W-1:0]         din0,
  input  logic [W-1:0]         din1,
  input  logic [W-1:0]         din2,
  input  logic [W-1:0]         din3,
  output logic [c_NUM_REQ-1:0] grant,
  output logic                 s0,
  output logic                 s1,
  output logic [W-1:0]         out,
  output logic                 out_valid
);

  localparam logic [3:0] c_HOLD_MAX = 4'(MAX_HOLD - 1);

  state_t                 r_state,  w_state_nxt;
  logic [c_NUM_REQ-1:0]   r_grant,  w_grant_nxt;
  logic [c_SEL_W-1:0]     r_sel,    w_sel_nxt;
  logic [c_SEL_W-1:0]     r_ptr,    w_ptr_nxt;
  logic [3:0]             r_hold,   w_hold_nxt;

  logic [c_NUM_REQ-1:0]   w_others;
  logic [c_NUM_REQ-1:0]   w_mask;
  logic                   w_move;
  logic [c_SEL_W-1:0]     w_pick;
  logic [W-1:0]           w_mux_y;

  assign w_others = req & ~r_grant;
  assign w_pick   = rr_pick(w_mask, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_mask      = '0;
    w_move      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_move = 1'b1;
          w_mask = req;
        end
      end
      default: begin
        if (req[r_sel]) begin
          if (r_hold < c_HOLD_MAX) begin
            w_hold_nxt = r_hold + 4'd1;
          end else if (|w_others) begin
            w_move = 1'b1;
            w_mask = w_others;
          end
          // Lone requester at the limit keeps the channel; counter saturates.
        end else if (|w_others) begin
          w_move = 1'b1;
          w_mask = w_others;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
    endcase

    if (w_move) begin
      w_state_nxt = ST_BUSY;
      w_grant_nxt = c_NUM_REQ'(1) << w_pick;
      w_sel_nxt   = w_pick;
      w_ptr_nxt   = w_pick + 2'd1;
      w_hold_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  mux4_w #(.W(W)) u_mux (
    .i_d0  (din0),
    .i_d1  (din1),
    .i_d2  (din2),
    .i_d3  (din3),
    .i_sel (r_sel),
    .o_y   (w_mux_y)
  );

  assign grant     = r_grant;
  assign s0        = r_sel[0];
  assign s1        = r_sel[1];
  assign out_valid = |r_grant;
  assign out       = out_valid ? w_mux_y : '0;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux4_arbiter.sv
// ============================================================
// tb_rr_mux4_arbiter : directed + constrained-random checks of rr_mux4_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

module tb_rr_mux4_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;
  localparam int c_WAIT_BOUND = 3 * MAX_HOLD + 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] din0, din1, din2, din3;
  logic [3:0]   grant;
  logic         s0, s1;
  logic [W-1:0] out;
  logic         out_valid;

  int n_checks = 0;
  int n_errors = 0;

  rr_mux4_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .grant     (grant),
    .s0        (s0),
    .s1        (s1),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [W-1:0] din_of(input int idx);
    case (idx)
      0:       return din0;
      1:       return din1;
      2:       return din2;
      default: return din3;
    endcase
  endfunction

  int wait_cnt [4];
  int max_wait;
  int gidx;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din0  = 8'hA0; din1 = 8'hB1; din2 = 8'hC2; din3 = 8'hD3;
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'({s1, s0}), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester 2 from reset
    req = 4'b0100;
    tick();
    chk("r2_grant", 32'(grant), 32'h4);
    chk("r2_sel", 32'({s1, s0}), 32'h2);
    chk("r2_out", 32'(out), 32'hC2);
    chk("r2_valid", 32'(out_valid), 32'h1);
    req = 4'b0000;
    tick();
    chk("r2_idle_grant", 32'(grant), 32'h0);
    chk("r2_idle_sel", 32'({s1, s0}), 32'h2);
    chk("r2_idle_out", 32'(out), 32'h0);

    // All requesting: 4-cycle bursts rotating 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 18; i++) begin
      tick();
      chk($sformatf("rot%0d", i), 32'(grant), 32'(4'b0001 << ((i / MAX_HOLD) % 4)));
    end

    // Lone requester saturates, then releases
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sat%0d", i), 32'(grant), 32'h1);
    end
    req = 4'b0000;
    tick();
    chk("sat_rel_grant", 32'(grant), 32'h0);
    chk("sat_rel_valid", 32'(out_valid), 32'h0);
    chk("sat_rel_sel", 32'({s1, s0}), 32'h0);

    // Granted requester 1 drops with 0 and 3 waiting: ptr=2 favours 3
    do_reset();
    req = 4'b0010;
    tick();
    chk("drop_g1", 32'(grant), 32'h2);
    req = 4'b1001;
    tick();
    chk("drop_g3", 32'(grant), 32'h8);
    chk("drop_out", 32'(out), 32'hD3);

    // Re-raise of a waiting requester does not pre-empt
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    tick();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    tick();
    chk("nopreempt", 32'(grant), 32'h1);
    tick();
    chk("move_at_limit", 32'(grant), 32'h2);

    // Async reset mid-grant
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    chk("mid_pre", 32'(grant), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("mid_after", 32'(grant), 32'h2);

    // Random requesters that hold req until served
    do_reset();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    max_wait = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (grant[i])      req[i] = ($urandom_range(0, 3) != 0);
        else if (!req[i])  req[i] = ($urandom_range(0, 2) == 0);
      end
      din0 = W'($urandom); din1 = W'($urandom);
      din2 = W'($urandom); din3 = W'($urandom);
      tick();
      chk("rnd_onehot0", 32'($countones(grant) <= 1), 32'h1);
      chk("rnd_valid", 32'(out_valid), 32'(grant != 4'b0000));
      gidx = 0;
      for (int i = 0; i < 4; i++) if (grant[i]) gidx = i;
      if (grant != 4'b0000) begin
        chk("rnd_sel", 32'({s1, s0}), 32'(gidx));
        chk("rnd_out", 32'(out), 32'(din_of(gidx)));
      end else begin
        chk("rnd_out_idle", 32'(out), 32'h0);
      end
      for (int i = 0; i < 4; i++) begin
        if (grant[i])     wait_cnt[i] = 0;
        else if (req[i])  wait_cnt[i]++;
        else              wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    chk("rnd_wait_bound", 32'(max_wait <= c_WAIT_BOUND), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
